// File: rtl/add_pipe.sv
// ---------------------------------------------------------------------------
// add_pipe
//
// Purpose:
//   Pipelined WIDTH-bit integer adder/subtractor with ready/valid handshakes
//   on both sides. The word is split into STAGES equal slices. Slice k is
//   added in pipeline stage k, using the carry registered by stage k-1. Each
//   slice is built from rippled 4-bit carry-lookahead groups. Operand slices
//   that are not yet needed travel down the pipe with their transaction, so
//   every transaction sees its own carries. Results appear exactly STAGES
//   cycles after acceptance. The whole pipe advances as one unit whenever
//   the output register is empty or is being drained.
//
//   WIDTH must be a multiple of 4*STAGES.
//
// Ports:
//   clk        in   1      clock, rising-edge active
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand set present
//   in_ready   out  1      operands accepted this cycle (== pipe advance)
//   a, b       in   WIDTH  two's-complement operands
//   op         in   2      00 ADD, 01 SUB, 10 ADC, 11 SBC
//   cin        in   1      carry-in for ADC/SBC
//   out_valid  out  1      result present
//   out_ready  in   1      consumer takes result this cycle
//   sum        out  WIDTH  result
//   cout       out  1      carry out of MSB (SUB/SBC: 1 = no borrow)
//   ovf        out  1      signed overflow
//   zf         out  1      result is zero
//   sf         out  1      result sign bit
// ---------------------------------------------------------------------------
module add_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zf,
    output logic             sf
);

    localparam int SW     = WIDTH / STAGES;
    localparam int GROUPS = SW / 4;

    // One 4-bit lookahead group: returns {carry out, carry into bit 3, sum}.
    // The carry into bit 3 is needed to derive signed overflow at the MSB.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        g  = x & y;
        p  = x ^ y;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, c3, p ^ {c3, c2, c1, c0}};
    endfunction

    // One slice: lookahead groups rippled together.
    // Returns {carry out, carry into slice MSB, slice sum}.
    function automatic logic [SW+1:0] addSlice(input logic [SW-1:0] x,
                                               input logic [SW-1:0] y,
                                               input logic          cIn);
        logic          c;
        logic          cMsb;
        logic [SW-1:0] s;
        logic [5:0]    grp;
        c    = cIn;
        cMsb = 1'b0;
        s    = '0;
        for (int i = 0; i < GROUPS; i++) begin
            grp        = cla4(x[4*i +: 4], y[4*i +: 4], c);
            s[4*i +: 4] = grp[3:0];
            cMsb       = grp[4];
            c          = grp[5];
        end
        return {c, cMsb, s};
    endfunction

    // Per-stage pipeline registers. Operand registers hold the slices still to
    // be added, shifted down so the next slice always sits in the low bits.
    logic [STAGES-1:0]            r_valid;
    logic [STAGES-1:0]            r_carry;
    logic [STAGES-1:0]            r_zero;
    logic [STAGES-1:0][WIDTH-1:0] r_a;
    logic [STAGES-1:0][WIDTH-1:0] r_b;
    logic [STAGES-1:0][WIDTH-1:0] r_sum;
    logic                         r_ovf;

    logic                         w_adv;
    logic [WIDTH-1:0]             w_bEff;
    logic                         w_cinEff;
    logic [STAGES-1:0]            w_srcValid;
    logic [STAGES-1:0]            w_srcCarry;
    logic [STAGES-1:0]            w_srcZero;
    logic [STAGES-1:0][WIDTH-1:0] w_srcA;
    logic [STAGES-1:0][WIDTH-1:0] w_srcB;
    logic [STAGES-1:0][WIDTH-1:0] w_srcSum;
    logic [STAGES-1:0][WIDTH-1:0] w_newSum;
    logic [STAGES-1:0]            w_newCarry;
    logic [STAGES-1:0]            w_newZero;
    logic                         w_cMsbLast;
    logic [2*WIDTH-1:0]           w_unusedOperands;

    // The pipe moves as one unit; a full output register being held back
    // freezes every stage, so nothing can be overwritten or dropped.
    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;

    // The last stage's operand registers are never consumed.
    assign w_unusedOperands = {r_a[STAGES-1], r_b[STAGES-1]};

    // Subtraction is addition of the inverted operand; the opcode only picks
    // the inversion and the initial carry.
    always_comb begin
        w_bEff = op[0] ? ~b : b;
        unique case (op)
            2'b00:   w_cinEff = 1'b0;
            2'b01:   w_cinEff = 1'b1;
            default: w_cinEff = cin;
        endcase
    end

    // Stage 0 takes the live inputs; later stages take the previous stage's
    // registers.
    always_comb begin
        w_srcValid[0] = in_valid;
        w_srcA[0]     = a;
        w_srcB[0]     = w_bEff;
        w_srcCarry[0] = w_cinEff;
        w_srcSum[0]   = '0;
        w_srcZero[0]  = 1'b1;
        for (int k = 1; k < STAGES; k++) begin
            w_srcValid[k] = r_valid[k-1];
            w_srcA[k]     = r_a[k-1];
            w_srcB[k]     = r_b[k-1];
            w_srcCarry[k] = r_carry[k-1];
            w_srcSum[k]   = r_sum[k-1];
            w_srcZero[k]  = r_zero[k-1];
        end
    end

    // Each stage adds its slice, merges it into the partial sum, and extends
    // the running zero flag. Only the last slice's MSB carry matters, for
    // overflow.
    always_comb begin
        logic [SW+1:0] res;
        res        = '0;
        w_cMsbLast = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            res                      = addSlice(w_srcA[k][SW-1:0], w_srcB[k][SW-1:0],
                                                w_srcCarry[k]);
            w_newSum[k]              = w_srcSum[k];
            w_newSum[k][k*SW +: SW]  = res[SW-1:0];
            w_newCarry[k]            = res[SW+1];
            w_newZero[k]             = w_srcZero[k] & (res[SW-1:0] == '0);
            if (k == STAGES - 1) begin
                w_cMsbLast = res[SW];
            end
        end
    end

    // Stage registers: cleared on reset, loaded together on advance, and
    // otherwise held. Bubbles move through as entries with the valid bit clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_carry <= '0;
            r_zero  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= w_srcValid[k];
                r_carry[k] <= w_newCarry[k];
                r_zero[k]  <= w_newZero[k];
                r_sum[k]   <= w_newSum[k];
                r_a[k]     <= w_srcA[k] >> SW;
                r_b[k]     <= w_srcB[k] >> SW;
            end
            r_ovf <= w_cMsbLast ^ w_newCarry[STAGES-1];
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign sum       = r_sum[STAGES-1];
    assign cout      = r_carry[STAGES-1];
    assign ovf       = r_ovf;
    assign zf        = r_zero[STAGES-1];
    assign sf        = r_sum[STAGES-1][WIDTH-1];

endmodule

// File: tb/tb_add_pipe.sv
// ---------------------------------------------------------------------------
// tb_add_pipe
//
// Purpose:
//   Self-checking bench for add_pipe (WIDTH=64, STAGES=4). The reference is a
//   queue of expected results computed with plain 65-bit arithmetic. Each
//   entry carries the number of pipe advances seen so far, which tells the
//   bench exactly when that entry must reach the output.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_add_pipe;

    localparam int WIDTH  = 64;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zf;
    logic             sf;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zf;
        logic             sf;
    } result_t;

    typedef struct {
        result_t res;
        int      tag;
    } entry_t;

    entry_t  expQ[$];
    int      advEdges = 0;
    int      nChecks  = 0;
    int      nFail    = 0;
    logic    started  = 1'b0;
    logic    heldActive = 1'b0;
    result_t heldRes;

    add_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zf        (zf),
        .sf        (sf)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Expected result from the arithmetic definition of each opcode.
    function automatic result_t refModel(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                         input logic [1:0] o, input logic c);
        logic [WIDTH-1:0] yy;
        logic             carryIn;
        logic [WIDTH:0]   full;
        result_t          r;
        yy      = o[0] ? ~y : y;
        carryIn = (o == 2'b00) ? 1'b0 : (o == 2'b01) ? 1'b1 : c;
        full    = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, carryIn};
        r.sum   = full[WIDTH-1:0];
        r.cout  = full[WIDTH];
        r.ovf   = (x[WIDTH-1] == yy[WIDTH-1]) && (r.sum[WIDTH-1] != x[WIDTH-1]);
        r.zf    = (r.sum == '0);
        r.sf    = r.sum[WIDTH-1];
        return r;
    endfunction

    // Operand source that favours the carry/overflow corner values.
    function automatic logic [WIDTH-1:0] randOperand();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b0, {(WIDTH-1){1'b1}}};
            3:       v = {1'b1, {(WIDTH-1){1'b0}}};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [WIDTH+7:0] act,
                               input logic [WIDTH+7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge and report whether the
    // operand set was taken at the following edge.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y, input logic [1:0] o,
                                 input logic c, input logic rdy, output logic accepted);
        in_valid  = v;
        a         = x;
        b         = y;
        op        = o;
        cin       = c;
        out_ready = rdy;
        @(negedge clk);
        accepted = v && in_ready && !rst;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        logic acc;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, acc);
        end
    endtask

    // Model bookkeeping at each rising edge. Values read here are the
    // pre-edge ones, i.e. what the design itself samples.
    always @(posedge clk) begin
        if (rst) begin
            expQ.delete();
            heldActive = 1'b0;
        end else begin
            heldActive = out_valid && !out_ready;
            heldRes    = {sum, cout, ovf, zf, sf};
            if (out_valid && out_ready && expQ.size() > 0) begin
                void'(expQ.pop_front());
            end
            if (out_ready || !out_valid) begin
                advEdges++;
                if (in_valid) begin
                    expQ.push_back('{res: refModel(a, b, op, cin), tag: advEdges});
                end
            end
        end
    end

    // Every cycle: the head entry must be at the output exactly when it has
    // seen enough advances, with the right values, and held outputs must not move.
    always @(negedge clk) begin
        logic expValid;
        if (started && !rst) begin
            expValid = (expQ.size() > 0) && (advEdges - expQ[0].tag >= STAGES - 1);
            checkOutput("out_valid", {8'h0, 63'h0, out_valid}, {8'h0, 63'h0, expValid});
            checkOutput("in_ready", {8'h0, 63'h0, in_ready},
                        {8'h0, 63'h0, (out_ready || !expValid)});
            if (expValid) begin
                checkOutput("sum",  {8'h0, sum},  {8'h0, expQ[0].res.sum});
                checkOutput("flags", {68'h0, cout, ovf, zf, sf},
                            {68'h0, expQ[0].res.cout, expQ[0].res.ovf,
                             expQ[0].res.zf, expQ[0].res.sf});
            end
            if (heldActive) begin
                checkOutput("hold", {4'h0, sum, cout, ovf, zf, sf}, {4'h0, heldRes});
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        result_t          r;
        logic             acc;
        int               idx;
        logic [WIDTH-1:0] sa [8];
        logic [WIDTH-1:0] sb [8];
        logic [1:0]       so [8];
        logic             sc [8];

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = 2'b00;
        cin       = 1'b0;
        out_ready = 1'b1;

        // Pin the reference model to hand-computed values.
        r = refModel(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 1'b0);
        checkOutput("model_add_ovf", {4'h0, r}, {4'h0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1});
        r = refModel(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 1'b0);
        checkOutput("model_add_wrap", {4'h0, r}, {4'h0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0});
        r = refModel(64'h5, 64'h5, 2'b01, 1'b0);
        checkOutput("model_sub_eq", {4'h0, r}, {4'h0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0});
        r = refModel(64'h0, 64'h0, 2'b11, 1'b0);
        checkOutput("model_sbc", {4'h0, r}, {4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1});

        // Two reset edges, then the cleared output state.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", {71'h0, out_valid}, 72'h0);
        checkOutput("rst_in_ready", {71'h0, in_ready}, 72'h1);
        checkOutput("rst_sum", {8'h0, sum}, 72'h0);
        checkOutput("rst_flags", {68'h0, cout, ovf, zf, sf}, 72'h0);
        started = 1'b1;
        @(posedge clk);
        #1;

        // Max positive + 1: result appears four cycles later.
        applyStimulus(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 1'b0, 1'b1, acc);
        idleCycles(STAGES - 1);
        checkOutput("lat_valid", {71'h0, out_valid}, 72'h1);
        checkOutput("lat_sum", {8'h0, sum}, {8'h0, 64'h8000_0000_0000_0000});
        checkOutput("lat_flags", {68'h0, cout, ovf, zf, sf}, {68'h0, 4'b0101});
        idleCycles(4);

        // Carry and borrow corner cases, back to back.
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 1'b0, 1'b1, acc);
        applyStimulus(1'b1, 64'h5, 64'h5, 2'b01, 1'b0, 1'b1, acc);
        applyStimulus(1'b1, 64'h0, 64'h0, 2'b11, 1'b0, 1'b1, acc);
        applyStimulus(1'b1, 64'h0, 64'h0, 2'b11, 1'b1, 1'b1, acc);
        idleCycles(8);

        // Eight back-to-back random ops with the consumer stalling mid-stream.
        for (int i = 0; i < 8; i++) begin
            sa[i] = randOperand();
            sb[i] = randOperand();
            so[i] = 2'($urandom_range(0, 3));
            sc[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (idx < 8) begin
                applyStimulus(1'b1, sa[idx], sb[idx], so[idx], sc[idx],
                              !(cyc >= STAGES + 2 && cyc <= STAGES + 4), acc);
                if (acc) idx++;
            end else begin
                applyStimulus(1'b0, '0, '0, 2'b00, 1'b0,
                              !(cyc >= STAGES + 2 && cyc <= STAGES + 4), acc);
            end
        end
        checkOutput("stream_all_sent", {64'h0, 8'(idx)}, 72'd8);
        idleCycles(6);

        // Alternating valid pattern with the consumer always ready.
        for (int cyc = 0; cyc < 12; cyc++) begin
            applyStimulus(cyc % 2 == 0, randOperand(), randOperand(),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, acc);
        end
        idleCycles(6);

        // Random valid/ready traffic.
        for (int cyc = 0; cyc < 300; cyc++) begin
            applyStimulus(1'($urandom_range(0, 1)), randOperand(), randOperand(),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0), acc);
        end
        idleCycles(8);

        // Reset with three ops in flight (and operands offered during reset).
        applyStimulus(1'b1, 64'h1, 64'h2, 2'b00, 1'b0, 1'b1, acc);
        applyStimulus(1'b1, 64'h3, 64'h4, 2'b01, 1'b0, 1'b1, acc);
        applyStimulus(1'b1, 64'h5, 64'h6, 2'b10, 1'b1, 1'b1, acc);
        rst = 1'b1;
        applyStimulus(1'b1, 64'h7, 64'h8, 2'b00, 1'b0, 1'b1, acc);
        rst = 1'b0;
        checkOutput("midrst_out_valid", {71'h0, out_valid}, 72'h0);
        checkOutput("midrst_sum", {8'h0, sum}, 72'h0);
        idleCycles(10);

        // Pipe still works after the flush.
        applyStimulus(1'b1, 64'h10, 64'h20, 2'b00, 1'b0, 1'b1, acc);
        idleCycles(8);

        checkOutput("queue_drained", {40'h0, 32'(expQ.size())}, 72'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/add_pipe.md
ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width in bits.
REQ-002 Parameter STAGES, default 4, number of register stages; WIDTH SHALL be a multiple of 4*STAGES (each stage spans WIDTH/STAGES bits built from 4-bit CLA groups).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a, b  input  WIDTH each  signed two's-complement operands.
REQ-008 op  input  2  00 ADD (a+b), 01 SUB (a+~b+1), 10 ADC (a+b+cin), 11 SBC (a+~b+cin).
REQ-009 cin  input  1  carry-in, used only by ADC/SBC.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 sum  output  WIDTH  result bits.
REQ-013 cout  output  1  carry out of MSB (for SUB/SBC: 1 = no borrow).
REQ-014 ovf  output  1  signed overflow.
REQ-015 zf  output  1  sum == 0.
REQ-016 sf  output  1  sum[WIDTH-1].

Function
REQ-017 Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-018 Global advance enable adv = out_ready || !out_valid; in_ready SHALL equal adv; all stages shift only when adv = 1, otherwise every stage holds contents.
REQ-019 Stage k (0..STAGES-1) SHALL add operand slice k using carry registered from stage k-1 (stage 0 uses effective cin: 0 ADD, 1 SUB, cin ADC/SBC); higher operand slices SHALL be delayed (skewed) until their stage.
REQ-020 Latency SHALL be exactly STAGES cycles from input transfer to out_valid when not stalled; throughput one result per cycle.
REQ-021 Each stage SHALL carry a valid bit; bubbles (in_valid = 0 with adv = 1) propagate as invalid entries; no result SHALL be dropped, duplicated, or reordered.
REQ-022 ovf SHALL equal carry into MSB XOR carry out of MSB of the full WIDTH sum.
REQ-023 zf SHALL be accumulated per stage as AND of slice-zero terms, final value reflecting all WIDTH bits.
REQ-024 sum, cout, ovf, zf, sf SHALL be held stable while out_valid && !out_ready.
REQ-025 Outputs when out_valid = 0 are don't-care for the consumer but SHALL not be X after reset.
REQ-026 Simultaneous input and output transfer in the same cycle SHALL be supported at full rate.

Reset
REQ-027 While rst = 1 at a clock edge: all stage valid bits cleared; next cycle out_valid = 0, in_ready = 1, sum = 0, cout = ovf = zf = sf = 0.
REQ-028 rst SHALL override in_valid in the same cycle; operands presented with rst = 1 are not accepted.
REQ-029 Reset mid-operation SHALL discard all in-flight results; none emerge afterward.

Verification (WIDTH=64, STAGES=4)
REQ-030 Assert rst 2 cycles -> out_valid = 0, in_ready = 1, all flags 0.
REQ-031 ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1, out_ready=1 -> 4 cycles later sum=0x8000_0000_0000_0000, ovf=1, cout=0, sf=1, zf=0.
REQ-032 ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> sum=0, cout=1, ovf=0, zf=1; SUB a=5, b=5 -> sum=0, cout=1, zf=1; SBC a=0, b=0, cin=0 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, sf=1.
REQ-033 Stream 8 back-to-back random ops, out_ready low cycles 3-5 of output -> in_ready low during stall, all 8 results match golden model in order, outputs stable while stalled.
REQ-034 Alternate in_valid 1/0 with out_ready=1 -> results emerge with same bubble pattern, 4-cycle latency each.
REQ-035 Accept 3 ops, assert rst while in flight -> out_valid = 0 next cycle and no result of those 3 ever appears.
